// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI raster timing generator.
// Holds the 640x480@60 default timing, FSM state codes and RGB field offsets.
package hdmi_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int CNT_W = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef logic [23:0] pixel_t;

endpackage

// File: rtl/hdmi_timing_counter.sv
// Horizontal/vertical raster counters with active, sync and origin flags.
// Counters are held at zero whenever run is low.
module hdmi_timing_counter
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             origin
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = 12'(V_TOTAL - 1);

    // 13-bit bounds so a sync window ending exactly at 4096 still compares correctly
    localparam logic [CNT_W:0] H_ACT_END = 13'(H_ACTIVE);
    localparam logic [CNT_W:0] HS_BEG    = 13'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_ACT_END = 13'(V_ACTIVE);
    localparam logic [CNT_W:0] VS_BEG    = 13'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic [CNT_W:0]   h_ext_s;
    logic [CNT_W:0]   v_ext_s;

    // Raster position: h wraps at H_TOTAL, v advances on each h wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= 12'd0;
            v_cnt_r <= 12'd0;
        end else if (!run) begin
            h_cnt_r <= 12'd0;
            v_cnt_r <= 12'd0;
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= 12'd0;
            v_cnt_r <= (v_cnt_r == V_LAST) ? 12'd0 : v_cnt_r + 12'd1;
        end else begin
            h_cnt_r <= h_cnt_r + 12'd1;
        end
    end

    assign h_ext_s = {1'b0, h_cnt_r};
    assign v_ext_s = {1'b0, v_cnt_r};

    assign h_cnt  = h_cnt_r;
    assign v_cnt  = v_cnt_r;
    assign active = (h_ext_s < H_ACT_END) & (v_ext_s < V_ACT_END);
    assign hs_raw = (h_ext_s >= HS_BEG) & (h_ext_s < HS_END);
    assign vs_raw = (v_ext_s >= VS_BEG) & (v_ext_s < VS_END);
    assign origin = (h_cnt_r == 12'd0) & (v_cnt_r == 12'd0);

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// Raster timing generator and pixel-stream aligner for the three TMDS encoders.
// Locks the incoming RGB stream to the raster on SOF and registers aligned video/sync outputs.
module hdmi_video_timing_gen
    import hdmi_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [23:0]      s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tuser,
    output logic             s_tready,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             hsync,
    output logic             vsync,
    output logic             vde,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             frame_start,
    output logic             underflow,
    output logic             sync_err
);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic       run_s;
    logic       active_s;
    logic       hs_raw_s;
    logic       vs_raw_s;
    logic       origin_s;
    logic       ready_s;
    pixel_t     pix_s;
    logic       underflow_s;
    logic       sync_err_s;

    logic [7:0] red_r;
    logic [7:0] green_r;
    logic [7:0] blue_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       vde_r;
    logic       frame_start_r;
    logic       underflow_r;
    logic       sync_err_r;

    assign run_s = en & (state_r != ST_IDLE);

    hdmi_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run_s),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active_s),
        .hs_raw (hs_raw_s),
        .vs_raw (vs_raw_s),
        .origin (origin_s)
    );

    // Stream alignment FSM: handshake, pixel selection and error pulses for the current position
    always_comb begin
        state_nxt_s = state_r;
        ready_s     = 1'b0;
        pix_s       = 24'd0;
        underflow_s = 1'b0;
        sync_err_s  = 1'b0;
        if (!en) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_SYNC;
                end
                ST_SYNC: begin
                    // drain non-SOF beats; hold an SOF beat until the raster reaches (0,0)
                    ready_s = ~(s_tvalid & s_tuser) | origin_s;
                    if (origin_s & s_tvalid & s_tuser) begin
                        pix_s       = s_tdata;
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_SYNC;
                    end
                end
                ST_RUN: begin
                    ready_s = active_s;
                    if (active_s & s_tvalid) begin
                        if (s_tuser != origin_s) begin
                            sync_err_s  = 1'b1;
                            state_nxt_s = ST_SYNC;
                        end else begin
                            pix_s = s_tdata;
                        end
                    end else if (active_s) begin
                        underflow_s = 1'b1;
                    end else begin
                        pix_s = 24'd0;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output stage: every output lags the counters by exactly one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_r         <= 8'd0;
            green_r       <= 8'd0;
            blue_r        <= 8'd0;
            hsync_r       <= ~HS_POL;
            vsync_r       <= ~VS_POL;
            vde_r         <= 1'b0;
            frame_start_r <= 1'b0;
            underflow_r   <= 1'b0;
            sync_err_r    <= 1'b0;
        end else begin
            red_r         <= pix_s[R_LSB +: 8];
            green_r       <= pix_s[G_LSB +: 8];
            blue_r        <= pix_s[B_LSB +: 8];
            hsync_r       <= (run_s & hs_raw_s) ~^ HS_POL;
            vsync_r       <= (run_s & vs_raw_s) ~^ VS_POL;
            vde_r         <= run_s & active_s;
            frame_start_r <= run_s & origin_s;
            underflow_r   <= underflow_s;
            sync_err_r    <= sync_err_s;
        end
    end

    assign s_tready    = ready_s;
    assign red         = red_r;
    assign green       = green_r;
    assign blue        = blue_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign vde         = vde_r;
    assign frame_start = frame_start_r;
    assign underflow   = underflow_r;
    assign sync_err    = sync_err_r;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Scoreboard bench for hdmi_video_timing_gen on a shrunken raster (30x15 clocks per frame).
// A driver runs a reference model each cycle and queues expectations; a monitor compares on the falling edge.
module tb_hdmi_video_timing_gen;

    localparam int HA  = 16;
    localparam int HFP = 4;
    localparam int HSW = 6;
    localparam int HBP = 4;
    localparam int VA  = 8;
    localparam int VFP = 2;
    localparam int VSW = 2;
    localparam int VBP = 3;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam logic HSP = 1'b0;
    localparam logic VSP = 1'b1;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        vde;
        logic        fs;
        logic        uf;
        logic        se;
    } out_t;

    typedef struct packed {
        logic [11:0] h;
        logic [11:0] v;
        logic        rdy;
        out_t        o;
    } exp_t;

    typedef struct packed {
        logic [23:0] data;
        logic        user;
        logic [3:0]  gap;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tuser;
    logic        s_tready;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        vde;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        frame_start;
    logic        underflow;
    logic        sync_err;

    exp_t  exp_q[$];
    beat_t src_q[$];
    int    total = 0;
    int    bad = 0;
    int    uf_seen = 0;
    int    se_seen = 0;

    bit    m_run;
    bit    m_lock;
    int    m_t;
    out_t  m_out;
    int    gap_cnt;
    logic  c_rst_n;
    logic  c_en;

    always #5 clk = ~clk;

    hdmi_video_timing_gen #(
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HSW),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VSW),
        .V_BP     (VBP),
        .HS_POL   (HSP),
        .VS_POL   (VSP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tuser     (s_tuser),
        .s_tready    (s_tready),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync       (hsync),
        .vsync       (vsync),
        .vde         (vde),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .frame_start (frame_start),
        .underflow   (underflow),
        .sync_err    (sync_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic out_t reset_out();
        out_t o;
        o.rgb = 24'd0;
        o.hs  = ~HSP;
        o.vs  = ~VSP;
        o.vde = 1'b0;
        o.fs  = 1'b0;
        o.uf  = 1'b0;
        o.se  = 1'b0;
        return o;
    endfunction

    // frame pixel (h,v) carries h + 256*v plus a random tag in the red byte
    task automatic push_frame(input int npix, input bit sof, input int gap_at, input int gap_len);
        beat_t b;
        logic [7:0] tag;
        tag = 8'($urandom_range(0, 255));
        for (int p = 0; p < npix; p++) begin
            b.data = {tag, 8'(p / HA), 8'(p % HA)};
            b.user = sof && (p == 0);
            b.gap  = (p == gap_at) ? 4'(gap_len) : 4'd0;
            src_q.push_back(b);
        end
    endtask

    // Reference behaviour for one clock: position from elapsed time, lock from SOF rules
    task automatic model_cycle(output exp_t e);
        int h, v;
        bit act, hs, vs, org, live, lock_n, rdy, uf, se;
        logic [23:0] pix;
        if (!rst_n) begin
            m_run  = 1'b0;
            m_lock = 1'b0;
            m_t    = 0;
            e.h    = 12'd0;
            e.v    = 12'd0;
            e.rdy  = 1'b0;
            e.o    = reset_out();
            m_out  = reset_out();
            return;
        end
        h   = m_run ? (m_t % HT) : 0;
        v   = m_run ? ((m_t / HT) % VT) : 0;
        act = (h < HA) && (v < VA);
        hs  = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vs  = (v >= VA + VFP) && (v < VA + VFP + VSW);
        org = (h == 0) && (v == 0);
        live = m_run && (en == 1'b1);
        rdy = 1'b0; pix = 24'd0; uf = 1'b0; se = 1'b0; lock_n = m_lock;
        if (live && !m_lock) begin
            rdy = !(s_tvalid && s_tuser) || org;
            if (org && s_tvalid && s_tuser) begin
                pix = s_tdata;
                lock_n = 1'b1;
            end
        end else if (live) begin
            rdy = act;
            if (act && s_tvalid) begin
                if (s_tuser != org) begin
                    se = 1'b1;
                    lock_n = 1'b0;
                end else begin
                    pix = s_tdata;
                end
            end else if (act) begin
                uf = 1'b1;
            end
        end
        e.h   = 12'(h);
        e.v   = 12'(v);
        e.rdy = rdy;
        e.o   = m_out;
        m_out.rgb = pix;
        m_out.hs  = (live && hs) ? HSP : ~HSP;
        m_out.vs  = (live && vs) ? VSP : ~VSP;
        m_out.vde = live && act;
        m_out.fs  = live && org;
        m_out.uf  = uf;
        m_out.se  = se;
        if (!en) begin
            m_run = 1'b0; m_lock = 1'b0; m_t = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_lock = 1'b0; m_t = 0;
        end else begin
            m_t++;
            m_lock = lock_n;
        end
    endtask

    task automatic drive_cycle();
        exp_t e;
        rst_n = c_rst_n;
        en    = c_en;
        s_tvalid = (src_q.size() > 0) && (gap_cnt == 0);
        if (s_tvalid) begin
            s_tdata = src_q[0].data;
            s_tuser = src_q[0].user;
        end else begin
            s_tdata = 24'($urandom);
            s_tuser = 1'($urandom_range(0, 1));
        end
        model_cycle(e);
        exp_q.push_back(e);
        if (s_tvalid && e.rdy) begin
            void'(src_q.pop_front());
            gap_cnt = (src_q.size() > 0) ? int'(src_q[0].gap) : 0;
        end else if (gap_cnt > 0) begin
            gap_cnt--;
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            drive_cycle();
        end
    endtask

    // Monitor: compare the queued expectation for this cycle away from the rising edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("h_cnt",       h_cnt,       e.h);
            chk("v_cnt",       v_cnt,       e.v);
            chk("s_tready",    s_tready,    e.rdy);
            chk("red",         red,         e.o.rgb[23:16]);
            chk("green",       green,       e.o.rgb[15:8]);
            chk("blue",        blue,        e.o.rgb[7:0]);
            chk("hsync",       hsync,       e.o.hs);
            chk("vsync",       vsync,       e.o.vs);
            chk("vde",         vde,         e.o.vde);
            chk("frame_start", frame_start, e.o.fs);
            chk("underflow",   underflow,   e.o.uf);
            chk("sync_err",    sync_err,    e.o.se);
            if (underflow === 1'b1) uf_seen++;
            if (sync_err === 1'b1) se_seen++;
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; s_tdata = 24'd0; s_tvalid = 1'b0; s_tuser = 1'b0;
        c_rst_n = 1'b0; c_en = 1'b0;
        m_run = 1'b0; m_lock = 1'b0; m_t = 0; m_out = reset_out();

        for (int i = 0; i < 50; i++) begin
            beat_t b;
            b.data = 24'($urandom);
            b.user = 1'b0;
            b.gap  = 4'($urandom_range(0, 2));
            src_q.push_back(b);
        end
        push_frame(HA * VA, 1'b1, -1, 0);
        // three-clock gap at (5,3); the frame is three beats short so the stream stays frame-aligned
        push_frame(HA * VA - 3, 1'b1, 3 * HA + 5, 3);
        push_frame(HA * VA, 1'b1, -1, 0);
        // truncated frame: the next SOF lands at pixel (5,5)
        push_frame(5 * HA + 5, 1'b1, -1, 0);
        push_frame(HA * VA, 1'b1, -1, 0);
        push_frame(HA * VA, 1'b1, -1, 0);
        // frame without SOF: its first beat arrives at (0,0) with tuser low
        push_frame(HA * VA, 1'b0, -1, 0);
        for (int f = 0; f < 6; f++) push_frame(HA * VA, 1'b1, -1, 0);
        gap_cnt = int'(src_q[0].gap);

        step(3);
        c_rst_n = 1'b1;
        step(4);
        c_en = 1'b1;
        step(3800);
        c_en = 1'b0;
        step(3);
        c_en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (m_run && m_lock && ((m_t % HT) == 10) && (((m_t / HT) % VT) == 5)) break;
            step(1);
        end
        c_rst_n = 1'b0;
        step(5);
        c_rst_n = 1'b1;
        step(1000);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("underflow_pulses",   uf_seen,      3);
        chk("sync_err_pulses",    se_seen,      2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
